// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and operand-signedness helpers for the iterative multiply/divide unit
package mdu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic logic is_div_op(op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic a_is_signed(op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - radix-2 shift-add multiplier / restoring divider, one bit per cycle, with valid/ready handshakes
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d, res_q, res_d;
  logic            neg_q, neg_d;

  op_e             op_in;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [2*W:0]    div_shift;
  logic [W:0]      div_diff;

  assign op_in     = op_e'(Operation);
  assign a_neg     = a_is_signed(op_in) & SrcA[W-1];
  assign b_neg     = b_is_signed(op_in) & SrcB[W-1];
  assign a_mag     = a_neg ? -SrcA : SrcA;
  assign b_mag     = b_neg ? -SrcB : SrcB;
  // Divide: acc holds {remainder, dividend/quotient}; mplier holds the divisor magnitude.
  assign div_shift = {acc_q, 1'b0};
  assign div_diff  = div_shift[2*W:W] - {1'b0, mplier_q};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;

  function automatic logic [W-1:0] finish_result(op_e op, logic neg, logic [2*W-1:0] acc);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[W-1:0] : acc[W-1:0];
    rem  = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      OP_MUL:                        return prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  return prod[2*W-1:W];
      OP_DIV, OP_DIVU:               return quo;
      default:                       return rem;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d  = op_in;
        cnt_d = '0;
        if (is_div_op(op_in) && SrcB == '0) begin
          res_d   = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : SrcA;
          state_d = DONE;
        end else if ((op_in inside {OP_DIV, OP_REM}) && SrcA == MOST_NEG && SrcB == '1) begin
          res_d   = (op_in == OP_DIV) ? SrcA : '0;
          state_d = DONE;
        end else begin
          // Remainder follows the dividend's sign; everything else the product/quotient sign.
          neg_d    = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
          mplier_d = b_mag;
          if (is_div_op(op_in)) begin
            acc_d   = {{W{1'b0}}, a_mag};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{W{1'b0}}, a_mag};
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (is_div_op(op_q)) begin
          acc_d = div_diff[W] ? div_shift[2*W-1:0]
                              : {div_diff[W-1:0], div_shift[W-1:1], 1'b1};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          res_d   = finish_result(op_q, neg_q, acc_d);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic reference model
`timescale 1ns/1ps
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   Operation = 3'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Result;

  mdu #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] res;
    int           acc_cyc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  int           force_stall = -1;
  int           stall = 0;
  logic         seen = 1'b0;
  logic [W-1:0] held = '0;

  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk_int(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: full-width 64-bit arithmetic, SV division already truncates toward zero.
  function automatic logic [W-1:0] model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin t = ua * ub;           return t[31:0];  end
      3'd1: begin t = sa * sb;           return t[63:32]; end
      3'd2: begin t = sa * longint'(ub); return t[63:32]; end
      3'd3: begin t = ua * ub;           return t[63:32]; end
      3'd4: begin if (b == 0) return '1; t = sa / sb; return t[31:0]; end
      3'd5: begin if (b == 0) return '1; t = ua / ub; return t[31:0]; end
      3'd6: begin if (b == 0) return a;  t = sa % sb; return t[31:0]; end
      default: begin if (b == 0) return a; t = ua % ub; return t[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 9));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
      return;
    end
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    @(posedge clk);
    #1;
    e.res     = model(op, a, b);
    e.acc_cyc = cyc - 1;
    e.lat     = model_lat(op, a, b);
    exp_q.push_back(e);
    in_valid  = 1'b0;
    Operation = 3'($urandom);
    SrcA      = W'($urandom);
    SrcB      = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      seen      = 1'b0;
      stall     = 0;
      out_ready = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_in_done", W'(in_ready), '0);
      if (!seen) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out_valid: Result %h with no request outstanding", Result);
        end else begin
          chk("result", Result, exp_q[0].res);
          chk_int("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
        end
        seen  = 1'b1;
        held  = Result;
        stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
      end else begin
        chk("result_stable", Result, held);
      end
      if (stall == 0) begin
        out_ready = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen = 1'b0;
      end else begin
        out_ready = 1'b0;
        stall--;
      end
    end else begin
      chk("in_ready_vs_busy", W'(in_ready), W'(exp_q.size() == 0));
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_result", Result, '0);

    chk("model_mul",     model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhu",   model(3'd3, '1, '1), 32'hFFFF_FFFE);
    chk("model_mulh",    model(3'd1, '1, '1), 32'h0000_0000);
    chk("model_mulhsu",  model(3'd2, '1, '1), 32'hFFFF_FFFF);
    chk("model_div",     model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem",     model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_divu",    model(3'd5, 32'hFFFF_FFF9, 32'd2), 32'h7FFF_FFFC);
    chk("model_divu0",   model(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("model_remu0",   model(3'd7, 32'd5, 32'd0), 32'd5);
    chk("model_div_ovf", model(3'd4, 32'h8000_0000, '1), 32'h8000_0000);
    chk("model_rem_ovf", model(3'd6, 32'h8000_0000, '1), 32'h0);
    chk("model_mul_3x4", model(3'd0, 32'd3, 32'd4), 32'd12);
    chk_int("model_lat_norm", model_lat(3'd0, 32'd7, 32'd3), 33);
    chk_int("model_lat_fast", model_lat(3'd7, 32'd5, 32'd0), 1);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd3, '1, '1);
    issue(3'd1, '1, '1);
    issue(3'd2, '1, '1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, '1);
    issue(3'd6, 32'h8000_0000, '1);
    drain();

    force_stall = 5;
    issue(3'd4, 32'd1000, 32'hFFFF_FFF3);
    issue(3'd7, 32'd9, 32'd0);
    drain();
    force_stall = -1;

    issue(3'd0, W'($urandom), W'($urandom));
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", W'(in_ready), W'(1));
    chk("post_reset_out_valid", W'(out_valid), '0);
    chk("post_reset_result", Result, '0);
    issue(3'd0, 32'd3, 32'd4);
    drain();

    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
